// File: rtl/act_quant_pipe.sv
// Multi-lane requantise + activation stage: per-lane rounding arithmetic right shift, then
// PASS/RELU/LEAKY/RELU_CLIP with saturation to DW bits, over a 2-stage valid/ready pipeline.
module act_quant_pipe #(
  parameter int unsigned DW       = 32,
  parameter int unsigned LANES    = 4,
  parameter int unsigned SHW      = 6,
  parameter int unsigned LEAKY_SH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_load_i,
  input  logic [1:0]              cfg_mode_i,
  input  logic [SHW-1:0]          cfg_shift_i,
  input  logic                    cfg_round_i,
  input  logic [DW-1:0]           cfg_clip_i,
  output logic                    cfg_err_o,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*2*DW-1:0]   in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*DW-1:0]     out_data_o,
  output logic [LANES-1:0]        out_sat_o,
  input  logic                    sat_clr_i,
  output logic [15:0]             sat_count_o,
  output logic                    busy_o
);

  localparam int unsigned WW = 2 * DW + 1;
  localparam logic signed [WW-1:0] MaxW = {{(WW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [WW-1:0] MinW = {{(WW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MaxD = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic [1:0] {ModePass, ModeRelu, ModeLeaky, ModeReluClip} mode_e;

  mode_e           cfg_mode_q;
  logic [SHW-1:0]  cfg_shift_q;
  logic            cfg_round_q;
  logic [DW-1:0]   cfg_clip_q;
  logic            cfg_err_q;

  logic                 s1_v_q;
  mode_e                s1_mode_q;
  logic [DW-1:0]        s1_clip_q;
  logic signed [WW-1:0] s1_q [LANES];
  logic signed [WW-1:0] s1_d [LANES];
  logic signed [WW-1:0] x_s  [LANES];
  logic signed [WW-1:0] rnd;

  logic                 s2_v_q;
  logic [LANES*DW-1:0]  out_data_q, out_data_d;
  logic [LANES-1:0]     out_sat_q, out_sat_d;
  logic signed [WW-1:0] y_s [LANES];
  logic signed [WW-1:0] clip_ext;

  logic [15:0] sat_count_q, sat_count_d;
  logic [16:0] pop, sum;
  logic        en1, en2, cfg_ok;

  assign en2    = !s2_v_q || out_ready_i;
  assign en1    = !s1_v_q || en2;
  assign cfg_ok = cfg_load_i && !(s1_v_q || s2_v_q) && !in_valid_i;

  // Stage 1: sign-extend one bit so the rounding add can never overflow.
  always_comb begin
    rnd = '0;
    if (cfg_round_q && (cfg_shift_q != '0)) begin
      rnd = {{(WW-1){1'b0}}, 1'b1} << (cfg_shift_q - SHW'(1));
    end
    for (int i = 0; i < LANES; i++) begin
      x_s[i]  = {in_data_i[i*2*DW + 2*DW - 1], in_data_i[i*2*DW +: 2*DW]} + rnd;
      s1_d[i] = x_s[i] >>> cfg_shift_q;
    end
  end

  // Stage 2: activation, then clamp; hitting clip is not counted as saturation.
  always_comb begin
    clip_ext   = {{(WW-DW){1'b0}}, s1_clip_q};
    out_data_d = '0;
    out_sat_d  = '0;
    for (int i = 0; i < LANES; i++) begin
      y_s[i] = s1_q[i];
      unique case (s1_mode_q)
        ModePass:     y_s[i] = s1_q[i];
        ModeRelu:     if (s1_q[i][WW-1]) y_s[i] = '0;
        ModeLeaky:    if (s1_q[i][WW-1]) y_s[i] = s1_q[i] >>> LEAKY_SH;
        ModeReluClip: begin
          if (s1_q[i][WW-1])          y_s[i] = '0;
          else if (s1_q[i] > clip_ext) y_s[i] = clip_ext;
        end
      endcase
      if (y_s[i] > MaxW) begin
        out_data_d[i*DW +: DW] = MaxW[DW-1:0];
        out_sat_d[i]           = 1'b1;
      end else if (y_s[i] < MinW) begin
        out_data_d[i*DW +: DW] = MinW[DW-1:0];
        out_sat_d[i]           = 1'b1;
      end else begin
        out_data_d[i*DW +: DW] = y_s[i][DW-1:0];
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + 17'(out_sat_q[i]);
    sum         = {1'b0, sat_count_q} + pop;
    sat_count_d = sat_count_q;
    if (sat_clr_i)                   sat_count_d = '0;
    else if (s2_v_q && out_ready_i) sat_count_d = sum[16] ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_mode_q  <= ModePass;
      cfg_shift_q <= '0;
      cfg_round_q <= 1'b0;
      cfg_clip_q  <= MaxD;
      cfg_err_q   <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_mode_q   <= ModePass;
      s1_clip_q   <= MaxD;
      s1_q        <= '{default: '0};
      s2_v_q      <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      sat_count_q <= '0;
    end else begin
      cfg_err_q <= cfg_load_i && !cfg_ok;
      if (cfg_ok) begin
        cfg_mode_q  <= mode_e'(cfg_mode_i);
        cfg_shift_q <= cfg_shift_i;
        cfg_round_q <= cfg_round_i;
        cfg_clip_q  <= cfg_clip_i;
      end
      if (en1) s1_v_q <= in_valid_i;
      // Mode/clip travel with the beat so later cfg loads never affect it.
      if (en1 && in_valid_i) begin
        s1_q      <= s1_d;
        s1_mode_q <= cfg_mode_q;
        s1_clip_q <= cfg_clip_q;
      end
      if (en2) s2_v_q <= s1_v_q;
      if (en2 && s1_v_q) begin
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
      end
      sat_count_q <= sat_count_d;
    end
  end

  assign cfg_err_o   = cfg_err_q;
  assign in_ready_o  = en1;
  assign out_valid_o = s2_v_q;
  assign out_data_o  = out_data_q;
  assign out_sat_o   = out_sat_q;
  assign sat_count_o = sat_count_q;
  assign busy_o      = s1_v_q || s2_v_q;

endmodule

// File: tb/tb_act_quant_pipe.sv
// Scoreboard bench for act_quant_pipe: a 128-bit reference model predicts each beat at
// acceptance; a negedge monitor pops and compares on every output transfer.
module tb_act_quant_pipe;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_load = 1'b0;
  logic [1:0]   cfg_mode = '0;
  logic [5:0]   cfg_shift = '0;
  logic         cfg_round = 1'b0;
  logic [31:0]  cfg_clip = '0;
  logic         cfg_err;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [3:0]   out_sat;
  logic         sat_clr = 1'b0;
  logic [15:0]  sat_count;
  logic         busy;

  act_quant_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load_i  (cfg_load),
    .cfg_mode_i  (cfg_mode),
    .cfg_shift_i (cfg_shift),
    .cfg_round_i (cfg_round),
    .cfg_clip_i  (cfg_clip),
    .cfg_err_o   (cfg_err),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_sat_o   (out_sat),
    .sat_clr_i   (sat_clr),
    .sat_count_o (sat_count),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   s;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           nvec = 0;
  int           nerr = 0;
  int           sc_model = 0;
  logic         held = 1'b0;
  logic [127:0] held_d;
  logic [3:0]   held_s;

  // Shadow of the configuration the DUT should hold.
  logic [1:0]  sh_mode = 2'd0;
  logic [5:0]  sh_shift = '0;
  logic        sh_round = 1'b0;
  logic [31:0] sh_clip = 32'h7FFF_FFFF;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [63:0] v, input logic [1:0] m, input logic [5:0] sh,
                                input logic rn, input logic [31:0] clip,
                                output logic [31:0] o, output logic s);
    logic signed [127:0] x, y, c;
    x = {{64{v[63]}}, v};
    c = {96'd0, clip};
    if (rn && sh != 6'd0) x = x + (128'sd1 <<< (sh - 6'd1));
    x = x >>> sh;
    case (m)
      2'd0:    y = x;
      2'd1:    y = (x < 0) ? 128'sd0 : x;
      2'd2:    y = (x < 0) ? (x >>> 3) : x;
      default: y = (x < 0) ? 128'sd0 : ((x > c) ? c : x);
    endcase
    if (y > 128'sd2147483647) begin
      o = 32'h7FFF_FFFF; s = 1'b1;
    end else if (y < -128'sd2147483648) begin
      o = 32'h8000_0000; s = 1'b1;
    end else begin
      o = y[31:0]; s = 1'b0;
    end
  endfunction

  function automatic logic [255:0] beat4(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] c, input logic [63:0] d);
    return {d, c, b, a};
  endfunction

  // Entered and left at posedge+1.
  task automatic send(input logic [255:0] d);
    exp_t        e;
    logic [31:0] o;
    logic        s;
    logic        ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        for (int i = 0; i < 4; i++) begin
          model(d[i*64 +: 64], sh_mode, sh_shift, sh_round, sh_clip, o, s);
          e.d[i*32 +: 32] = o;
          e.s[i]          = s;
        end
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    check_val("in_accept", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [5:0] sh, input logic rn,
                     input logic [31:0] clip);
    cfg_load = 1'b1; cfg_mode = m; cfg_shift = sh; cfg_round = rn; cfg_clip = clip;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    sh_mode = m; sh_shift = sh; sh_round = rn; sh_clip = clip;
    @(negedge clk);
    check_val("cfg_err_idle", cfg_err, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    logic ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("drain", ok, 1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
      exp_q.delete();
      sc_model = 0;
    end else begin
      if (held) begin
        check_val("stall_valid", out_valid, 1);
        check_val("stall_data", out_data, held_d);
        check_val("stall_sat", out_sat, held_s);
      end
      held   = out_valid && !out_ready;
      held_d = out_data;
      held_s = out_sat;
      if (out_valid && out_ready) begin
        check_val("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_val("out_data", out_data, mon_e.d);
          check_val("out_sat", out_sat, mon_e.s);
        end
        if (sat_clr) sc_model = 0;
        else sc_model = (sc_model + $countones(out_sat) > 65535) ? 65535
                                                                 : sc_model + $countones(out_sat);
      end else if (sat_clr) begin
        sc_model = 0;
      end
    end
  end

  initial begin
    logic ok;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_cfg_err", cfg_err, 0);
    check_val("rst_sat_count", sat_count, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_sat", out_sat, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Default config is PASS, shift 0.
    send(beat4(64'd5, -64'sd7, 64'd0, 64'd100));
    wait_idle();

    // T1 with a latency probe.
    cfg(2'd0, 6'd8, 1'b0, 32'h7FFF_FFFF);
    send(beat4(64'h1234_5600, -64'sd256, 64'h7F_FFFF_FFFF, 64'h1FF));
    @(negedge clk);
    check_val("lat_cycle1", out_valid, 0);
    @(negedge clk);
    check_val("lat_cycle2", out_valid, 1);
    check_val("t1_lane0", out_data[31:0], 32'h0012_3456);
    check_val("t1_sat", out_sat, 4'b0000);
    wait_idle();

    cfg(2'd1, 6'd4, 1'b1, 32'h7FFF_FFFF);
    send(beat4(-64'sd40, 64'd40, 64'd24, -64'sd1));
    wait_idle();

    cfg(2'd2, 6'd0, 1'b0, 32'h7FFF_FFFF);
    send(beat4(-64'sd64, 64'd100, -64'sd8, 64'd0));
    wait_idle();
    cfg(2'd0, 6'd0, 1'b0, 32'h7FFF_FFFF);
    send(beat4(64'd1 << 40, -(64'sd1 <<< 40), 64'd5, -64'sd5));
    wait_idle();
    check_val("t3_sat_count", sat_count, 2);

    cfg(2'd3, 6'd0, 1'b0, 32'h600);
    send(beat4(64'h700, -64'sd5, 64'h5FF, 64'h7FFF_FFFF_FFFF));
    wait_idle();

    cfg(2'd0, 6'd63, 1'b1, 32'h7FFF_FFFF);
    send(beat4(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_FFFF));
    wait_idle();

    // T5: backpressure stream.
    cfg(2'd2, 6'd1, 1'b1, 32'h7FFF_FFFF);
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(beat4({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                     {24'd0, 8'(k), $urandom}));
      end
      begin
        for (int k = 0; k < 30; k++) begin
          out_ready = ~out_ready;
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();
    check_val("t5_sat_count", sat_count, 32'(sc_model));

    // T6: cfg_load while busy is rejected.
    cfg(2'd0, 6'd0, 1'b0, 32'h7FFF_FFFF);
    send(beat4(-64'sd3, 64'd3, 64'd0, 64'd1));
    cfg_load = 1'b1; cfg_mode = 2'd1;
    @(negedge clk);
    check_val("t6_busy", busy, 1);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    @(negedge clk);
    check_val("t6_cfg_err", cfg_err, 1);
    @(negedge clk);
    check_val("t6_cfg_err_pulse", cfg_err, 0);
    wait_idle();
    send(beat4(-64'sd64, -64'sd1, 64'd9, 64'd0));
    wait_idle();

    // T6: sat_clr coincident with a saturating transfer.
    check_val("t6_pre_clr_nonzero", sat_count != 0, 1);
    out_ready = 1'b0;
    send(beat4(64'd1 << 40, 64'd0, 64'd0, 64'd0));
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("t6_out_valid", ok, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    sat_clr   = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    @(negedge clk);
    check_val("t6_sat_clr", sat_count, 0);
    wait_idle();

    // Reset with beats in flight.
    out_ready = 1'b0;
    send(beat4(64'd11, 64'd12, 64'd13, 64'd14));
    send(beat4(64'd21, 64'd22, 64'd23, 64'd24));
    rst_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    sh_mode = 2'd0; sh_shift = '0; sh_round = 1'b0; sh_clip = 32'h7FFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("post_rst_idle", out_valid, 0);
    end
    @(posedge clk); #1;
    send(beat4(64'd1 << 35, -64'sd2, 64'd2, 64'd77));
    wait_idle();
    check_val("final_sat_count", sat_count, 32'(sc_model));
    check_val("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
